// File: rtl/fp_acc_pkg.sv
// Shared types and helpers for the floating-point accumulation controller.
// The adder itself lives outside this block; only the controller types are here.
package fp_acc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FIRST = 3'd1,
    S_ACCUM = 3'd2,
    S_ADD   = 3'd3,
    S_DONE  = 3'd4
  } fp_acc_state_t;

  // Total bit width of a sign/exponent/mantissa word.
  function automatic int fp_width(input int exp_width, input int mantissa_width);
    return exp_width + mantissa_width + 1;
  endfunction

endpackage

// File: rtl/fp_acc_fsm.sv
// Control FSM for fp_accumulator: state register, next-state logic and the
// ready/done decode. Datapath registers are kept in the top level.
module fp_acc_fsm
  import fp_acc_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          valid,
  input  logic          len_is_one,
  input  logic          add_is_last,
  output fp_acc_state_t state,
  output logic          ready,
  output logic          done
);

  fp_acc_state_t state_q;
  fp_acc_state_t state_d;

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = S_FIRST;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_FIRST: if (valid) state_d = len_is_one ? S_DONE : S_ACCUM;
        S_ACCUM: if (valid) state_d = S_ADD;
        S_ADD:   state_d = add_is_last ? S_DONE : S_ACCUM;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;
  assign ready = (state_q == S_FIRST) || (state_q == S_ACCUM);
  assign done  = (state_q == S_DONE);

endmodule

// File: rtl/fp_accumulator.sv
// Accumulation controller wrapped around an external combinational fp_adder:
// running sum register, registered sample, counter and sticky adder flags.
module fp_accumulator
  import fp_acc_pkg::*;
#(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int COUNT_WIDTH    = 8,
  parameter int W              = fp_width(EXP_WIDTH, MANTISSA_WIDTH)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic [COUNT_WIDTH-1:0] len_in,
  input  logic [W-1:0]           data_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic [W-1:0]           adder_a_out,
  output logic [W-1:0]           adder_b_out,
  input  logic [W-1:0]           adder_sum_in,
  input  logic                   adder_overflow_in,
  input  logic                   adder_underflow_in,
  output logic [W-1:0]           acc_out,
  output logic [COUNT_WIDTH-1:0] count_out,
  output logic                   overflow_out,
  output logic                   underflow_out,
  output logic                   done_out
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

  fp_acc_state_t          state;
  logic [W-1:0]           acc_q;
  logic [W-1:0]           b_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] len_q;
  logic [COUNT_WIDTH-1:0] count_next;
  logic                   overflow_q;
  logic                   underflow_q;
  logic                   len_is_one;
  logic                   add_is_last;

  assign count_next  = count_q + COUNT_ONE;
  assign len_is_one  = (len_q == COUNT_ONE);
  assign add_is_last = (count_next == len_q);

  fp_acc_fsm u_fsm (
    .clk         (clk_in),
    .rst         (rst_in),
    .start       (start_in),
    .valid       (valid_in),
    .len_is_one  (len_is_one),
    .add_is_last (add_is_last),
    .state       (state),
    .ready       (ready_out),
    .done        (done_out)
  );

  // start_in wins over any handshake; FIRST bypasses the adder since it
  // cannot produce an exact zero to seed the sum with.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_q       <= '0;
      b_q         <= '0;
      count_q     <= '0;
      len_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (start_in) begin
      len_q       <= (len_in == '0) ? COUNT_ONE : len_in;
      count_q     <= '0;
      acc_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      case (state)
        S_FIRST: begin
          if (valid_in) begin
            acc_q   <= data_in;
            count_q <= COUNT_ONE;
          end
        end
        S_ACCUM: begin
          if (valid_in) begin
            b_q <= data_in;
          end
        end
        S_ADD: begin
          acc_q       <= adder_sum_in;
          count_q     <= count_next;
          overflow_q  <= overflow_q | adder_overflow_in;
          underflow_q <= underflow_q | adder_underflow_in;
        end
        default: ;
      endcase
    end
  end

  assign adder_a_out   = acc_q;
  assign adder_b_out   = b_q;
  assign acc_out       = acc_q;
  assign count_out     = count_q;
  assign overflow_out  = overflow_q;
  assign underflow_out = underflow_q;

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator with a lookup-table adder model and a
// scoreboard of expected run results compared on each done pulse.
module tb_fp_accumulator;

  logic        clk_in;
  logic        rst_in;
  logic        start_in;
  logic [7:0]  len_in;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] adder_a_out;
  logic [31:0] adder_b_out;
  logic [31:0] adder_sum_in;
  logic        adder_overflow_in;
  logic        adder_underflow_in;
  logic [31:0] acc_out;
  logic [7:0]  count_out;
  logic        overflow_out;
  logic        underflow_out;
  logic        done_out;

  typedef struct {
    logic [31:0] acc;
    logic [7:0]  count;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   checks;
  int   failures;
  int   done_count;

  fp_accumulator dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .start_in           (start_in),
    .len_in             (len_in),
    .data_in            (data_in),
    .valid_in           (valid_in),
    .ready_out          (ready_out),
    .adder_a_out        (adder_a_out),
    .adder_b_out        (adder_b_out),
    .adder_sum_in       (adder_sum_in),
    .adder_overflow_in  (adder_overflow_in),
    .adder_underflow_in (adder_underflow_in),
    .acc_out            (acc_out),
    .count_out          (count_out),
    .overflow_out       (overflow_out),
    .underflow_out      (underflow_out),
    .done_out           (done_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Adder model restricted to the operand pairs this bench produces.
  always_comb begin
    adder_sum_in       = 32'h0;
    adder_overflow_in  = 1'b0;
    adder_underflow_in = 1'b0;
    case ({adder_a_out, adder_b_out})
      {32'h3F800000, 32'h40000000}: adder_sum_in = 32'h40400000;
      {32'h40400000, 32'h40400000}: adder_sum_in = 32'h40C00000;
      {32'h3F800000, 32'h3F800000}: adder_sum_in = 32'h40000000;
      {32'h7F000000, 32'h7F000000}: begin
        adder_sum_in      = 32'h7F800000;
        adder_overflow_in = 1'b1;
      end
      default: ;
    endcase
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic apply_start(input logic [7:0] len);
    start_in = 1'b1;
    len_in   = len;
    step(1);
    start_in = 1'b0;
  endtask

  // Hold valid until a transfer happens, bounded to a few cycles.
  task automatic apply_stimulus(input logic [31:0] data);
    logic accepted;
    accepted = 1'b0;
    valid_in = 1'b1;
    data_in  = data;
    for (int i = 0; i < 8 && !accepted; i++) begin
      accepted = ready_out;
      step(1);
    end
    valid_in = 1'b0;
    check_output("handshake", {31'b0, accepted}, 32'd1);
  endtask

  always @(negedge clk_in) begin
    if (done_out) begin
      done_count++;
      if (sb_q.size() == 0) begin
        check_output("sb_pending", 32'(sb_q.size()), 32'd1);
      end else begin
        sb_e = sb_q.pop_front();
        check_output("sb_acc", acc_out, sb_e.acc);
        check_output("sb_count", {24'b0, count_out}, {24'b0, sb_e.count});
        check_output("sb_ovf", {31'b0, overflow_out}, {31'b0, sb_e.ovf});
        check_output("sb_unf", {31'b0, underflow_out}, {31'b0, sb_e.unf});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] samples [3];
    logic        exp_ready [5];
    int          idx;
    logic        took;

    checks = 0; failures = 0; done_count = 0;
    rst_in = 1'b1; start_in = 1'b0; len_in = '0; data_in = '0; valid_in = 1'b0;
    step(2);
    check_output("rst_acc", acc_out, 32'h0);
    check_output("rst_count", {24'b0, count_out}, 32'h0);
    check_output("rst_ready", {31'b0, ready_out}, 32'h0);
    check_output("rst_done", {31'b0, done_out}, 32'h0);
    check_output("rst_flags", {30'b0, overflow_out, underflow_out}, 32'h0);
    check_output("rst_adder_ops", adder_a_out | adder_b_out, 32'h0);
    rst_in = 1'b0;
    step(1);

    // Three-sample sum
    apply_start(8'd3);
    check_output("t3_first_ready", {31'b0, ready_out}, 32'd1);
    sb_q.push_back('{acc: 32'h40C00000, count: 8'd3, ovf: 1'b0, unf: 1'b0});
    apply_stimulus(32'h3F800000);
    check_output("t3_acc1", acc_out, 32'h3F800000);
    apply_stimulus(32'h40000000);
    check_output("t3_add_a", adder_a_out, 32'h3F800000);
    check_output("t3_add_b", adder_b_out, 32'h40000000);
    check_output("t3_add_ready", {31'b0, ready_out}, 32'd0);
    step(1);
    check_output("t3_acc2", acc_out, 32'h40400000);
    apply_stimulus(32'h40400000);
    step(1);
    check_output("t3_done", {31'b0, done_out}, 32'd1);
    step(1);
    check_output("t3_done_clear", {31'b0, done_out}, 32'd0);
    check_output("t3_acc_hold", acc_out, 32'h40C00000);
    check_output("t3_count_hold", {24'b0, count_out}, 32'd3);

    // Single sample, then zero length
    for (int k = 0; k < 2; k++) begin
      apply_start(k == 0 ? 8'd1 : 8'd0);
      sb_q.push_back('{acc: 32'h40490FDB, count: 8'd1, ovf: 1'b0, unf: 1'b0});
      apply_stimulus(32'h40490FDB);
      check_output("single_done", {31'b0, done_out}, 32'd1);
      check_output("single_acc", acc_out, 32'h40490FDB);
      step(1);
    end

    // Backpressure: valid held high, ready alternates once running
    samples[0] = 32'h3F800000; samples[1] = 32'h40000000; samples[2] = 32'h40400000;
    exp_ready[0] = 1'b1; exp_ready[1] = 1'b1; exp_ready[2] = 1'b0;
    exp_ready[3] = 1'b1; exp_ready[4] = 1'b0;
    apply_start(8'd3);
    sb_q.push_back('{acc: 32'h40C00000, count: 8'd3, ovf: 1'b0, unf: 1'b0});
    idx = 0;
    valid_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_output("bp_ready", {31'b0, ready_out}, {31'b0, exp_ready[i]});
      data_in = samples[idx < 3 ? idx : 2];
      took = ready_out;
      step(1);
      if (took) idx++;
    end
    valid_in = 1'b0;
    check_output("bp_transfers", idx, 32'd3);
    check_output("bp_done", {31'b0, done_out}, 32'd1);
    step(1);

    // Valid gaps stall in ACCUM without touching the count
    apply_start(8'd2);
    sb_q.push_back('{acc: 32'h40000000, count: 8'd2, ovf: 1'b0, unf: 1'b0});
    apply_stimulus(32'h3F800000);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_output("gap_count", {24'b0, count_out}, 32'd1);
      check_output("gap_ready", {31'b0, ready_out}, 32'd1);
    end
    apply_stimulus(32'h3F800000);
    step(2);

    // Overflow is sticky through DONE
    apply_start(8'd2);
    sb_q.push_back('{acc: 32'h7F800000, count: 8'd2, ovf: 1'b1, unf: 1'b0});
    apply_stimulus(32'h7F000000);
    apply_stimulus(32'h7F000000);
    step(1);
    check_output("ovf_after_add", {31'b0, overflow_out}, 32'd1);
    step(1);
    check_output("ovf_hold", {31'b0, overflow_out}, 32'd1);

    // Restart during ADD of a len=4 run
    apply_start(8'd4);
    check_output("ovf_cleared", {31'b0, overflow_out}, 32'd0);
    apply_stimulus(32'h3F800000);
    apply_stimulus(32'h40000000);
    check_output("rs_in_add", {31'b0, ready_out}, 32'd0);
    apply_start(8'd2);
    check_output("rs_ready", {31'b0, ready_out}, 32'd1);
    check_output("rs_count", {24'b0, count_out}, 32'd0);
    check_output("rs_acc", acc_out, 32'h0);
    check_output("rs_flags", {30'b0, overflow_out, underflow_out}, 32'd0);
    sb_q.push_back('{acc: 32'h40000000, count: 8'd2, ovf: 1'b0, unf: 1'b0});
    apply_stimulus(32'h3F800000);
    apply_stimulus(32'h3F800000);
    step(2);

    // Asynchronous reset during ACCUM
    apply_start(8'd3);
    apply_stimulus(32'h3F800000);
    #2 rst_in = 1'b1;
    #1;
    check_output("arst_acc", acc_out, 32'h0);
    check_output("arst_count", {24'b0, count_out}, 32'd0);
    check_output("arst_ready", {31'b0, ready_out}, 32'd0);
    check_output("arst_done", {31'b0, done_out}, 32'd0);
    step(1);
    rst_in = 1'b0;
    step(3);
    check_output("arst_idle_ready", {31'b0, ready_out}, 32'd0);

    check_output("done_pulses", done_count, 32'd7);
    check_output("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_accumulator.md
# fp_accumulator

Sequential accumulation controller that drives the combinational floating-point adder (`fp_adder`) in a feedback loop. It accepts a stream of IEEE-754-style samples over a valid/ready handshake and keeps a running sum in a register. It presents `{acc, sample}` to the adder and captures the adder's result and flags. It reports completion after a programmed number of samples.

## Interface
- `EXP_WIDTH`, default 8: exponent width; must match the adder instance.
- `MANTISSA_WIDTH`, default 23: stored mantissa width; must match the adder instance.
- `COUNT_WIDTH`, default 8: width of the sample counter and length input.
- Word width `W = EXP_WIDTH+MANTISSA_WIDTH+1` is used throughout.
- `clk_in`  in  1  single clock; all state updates on the rising edge.
- `rst_in`  in  1  asynchronous, active-high reset.
- `start_in`  in  1  begin a new accumulation; samples `len_in`.
- `len_in`  in  COUNT_WIDTH  number of samples to sum; 0 is treated as 1.
- `data_in`  in  W  sample word.
- `valid_in`  in  1  `data_in` is valid.
- `ready_out`  out  1  block accepts a sample this cycle.
- `adder_a_out`  out  W  to adder `a_in`; the accumulator register.
- `adder_b_out`  out  W  to adder `b_in`; the registered sample.
- `adder_sum_in`  in  W  from adder `fpa_out`.
- `adder_overflow_in`, `adder_underflow_in`  in  1 each  from adder flags.
- `acc_out`  out  W  current accumulator value.
- `count_out`  out  COUNT_WIDTH  samples absorbed so far.
- `overflow_out`, `underflow_out`  out  1 each  sticky OR of adder flags captured during this run.
- `done_out`  out  1  one-cycle pulse when the run completes.

## Operation
- **States:** IDLE, FIRST, ACCUM, ADD, DONE.
- **IDLE:** `ready_out`=0. On `start_in` go to FIRST, and in the same edge:
  - latch `len_in` (0→1);
  - clear `count`, `acc` and the sticky flags.
- **FIRST:** `ready_out`=1. On `valid_in`:
  - `acc` ← `data_in` directly, bypassing the adder, because the adder cannot represent zero;
  - `count` ← 1;
  - go to DONE if `len`==1, else to ACCUM.
- **ACCUM:** `ready_out`=1. On `valid_in`: `b_reg` ← `data_in`, go to ADD.
- **ADD:** `ready_out`=0. `adder_a_out`=`acc` and `adder_b_out`=`b_reg`, both register outputs and stable all cycle. At the end of the cycle:
  - `acc` ← `adder_sum_in`;
  - `count` += 1;
  - `overflow` |= `adder_overflow_in`; `underflow` |= `adder_underflow_in`;
  - go to DONE if the new `count`==`len`, else to ACCUM.
- **DONE:** `done_out`=1 for exactly one cycle, then IDLE. `acc_out`, `count_out` and the flags hold until the next `start_in`.
- **`start_in` in any non-IDLE state:** aborts the run, performs the same clears as from IDLE, and goes to FIRST. It has priority over a simultaneous `valid_in` handshake.
- **Handshake:** a transfer occurs only when `valid_in && ready_out`. `data_in` is don't-care otherwise.
- **Counter:** `count` never exceeds `len`, so there is no wrap.

## Timing
- **Reset values:** state IDLE. `ready_out`, `done_out`, `overflow_out` and `underflow_out` are 0. `acc_out`, `count_out`, `adder_a_out` and `adder_b_out` are 0.
- **Throughput:** one sample per 2 cycles in steady state. The first sample takes 1 cycle.
- **Latency:** a sample accepted in ACCUM at cycle k is added during k+1. Its sum appears on `acc_out` at k+2.
- **`done_out`:** asserted the cycle after the final capture.
- **Adder timing:** the adder path is purely combinational within the ADD cycle. The `adder_sum_in` to `acc` path must meet a single cycle.

## Structure
- **Package `fp_acc_pkg`:**
  - state enum typedef `fp_acc_state_t`;
  - helper function `fp_width(EXP_WIDTH, MANTISSA_WIDTH)`.
- **Adder:** not instantiated inside. The parent connects `fp_adder` between `adder_*_out` and `adder_*_in`.
- **Sub-module `fp_acc_fsm`:** holds the state register, next-state logic and `ready_out`/`done_out` decode. The datapath registers stay in the top.

## Test plan
- **Three-sample sum:** `len`=3, samples 0x3F800000, 0x40000000, 0x40400000.
  - `acc` goes 0x3F800000 → 0x40400000 → 0x40C00000.
  - `count_out`=3; one `done_out` pulse; flags 0.
- **Single sample and zero length:** with `len`=1 and with `len`=0, sample 0x40490FDB.
  - `acc_out`=0x40490FDB.
  - `done_out` the cycle after acceptance; the adder is never used.
- **Backpressure:** `valid_in` held high throughout.
  - `ready_out` toggles 1,0,1,0.
  - Exactly one transfer per ACCUM cycle.
  - `valid_in` gaps stall in ACCUM with no count change.
- **Overflow:** `len`=2, samples 0x7F000000 and 0x7F000000.
  - `overflow_out`=1 after ADD, held through DONE.
  - Cleared by the next `start_in`.
- **Restart mid-run:** `start_in` asserted during ADD of a `len`=4 run.
  - Next state FIRST; `count_out`=0; flags clear; `acc_out`=0.
  - A new `len`=2 run then sums 0x3F800000 + 0x3F800000 = 0x40000000.
- **Reset mid-run:** assert `rst_in` asynchronously during ACCUM.
  - All outputs go to reset values immediately, without waiting for a clock edge.
  - No `done_out` pulse.
